// File: rtl/apb_slave_mem_pkg.sv
// apb_slave_mem_pkg: shared APB types, constants and helpers (package apb_pkg)
package apb_pkg;

    localparam int APB_ADDR_LSB = 2;
    localparam int APB_DATA_W   = 32;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_slv_state_t;

    // Command encodings driven into the master; kept here so both ends agree
    typedef enum logic [1:0] {
        APB_CMD_NOP   = 2'b00,
        APB_CMD_READ  = 2'b01,
        APB_CMD_WRITE = 2'b10
    } apb_cmd_t;

    // True when a byte address is misaligned or falls beyond a DEPTH-word window
    function automatic logic apb_addr_bad(input logic [31:0] addr, input int depth);
        return (addr >= 32'(depth * 4)) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus bundle between master and slave; pslverr_o present with APB_SLAVE_PSLVERR_EN
interface apb_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              psel_i;
    logic              penable_i;
    logic [ADDR_W-1:0] paddr_i;
    logic              pwrite_i;
    logic [DATA_W-1:0] pwdata_i;
    logic              pready_o;
    logic [DATA_W-1:0] prdata_o;

`ifdef APB_SLAVE_PSLVERR_EN
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );
`else
    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o
    );
`endif

endinterface

// File: rtl/apb_slave_mem_regfile.sv
// apb_slv_regfile: DEPTH x DATA_W word store with synchronous write, registered read and synchronous clear
module apb_slv_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear everything on reset; otherwise commit writes and capture reads (rzero forces a zero read)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave word memory with fixed wait states; APB_SLAVE_PSLVERR_EN adds pslverr_o error signalling
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = APB_DATA_W
) (
    input logic           clk,
    input logic           reset,
    apb_slave_mem_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    apb_slv_state_t    state;
    logic [3:0]        cnt;
    logic [IW-1:0]     idx;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              setup;
    logic              done;
    logic              rzero;
    logic              blocked;
    logic              unused_addr;

    assign setup        = state == IDLE && bus.psel_i && !bus.penable_i;
    assign bus.pready_o = state == ACCESS && cnt == '0;
    assign done         = bus.pready_o && bus.psel_i && bus.penable_i;
    assign unused_addr  = ^bus.paddr_i;

`ifdef APB_SLAVE_PSLVERR_EN
    logic setup_err;
    logic err;

    assign setup_err     = apb_addr_bad(32'(bus.paddr_i), DEPTH);
    assign rzero         = setup_err;
    assign blocked       = err;
    assign bus.pslverr_o = bus.pready_o && err;

    // Remember whether the transfer being served was flagged at its setup edge
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else if (setup) err <= setup_err;
    end
`else
    assign rzero   = 1'b0;
    assign blocked = 1'b0;
`endif

    // Setup latches the request; access counts down wait states, completes, or aborts when psel drops
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            wr    <= 1'b0;
            wdata <= '0;
        end else if (setup) begin
            state <= ACCESS;
            cnt   <= 4'(WAIT_CYCLES);
            idx   <= bus.paddr_i[APB_ADDR_LSB +: IW];
            wr    <= bus.pwrite_i;
            wdata <= bus.pwdata_i;
        end else if (state == ACCESS && (!bus.psel_i || done)) begin
            state <= IDLE;
        end else if (state == ACCESS && cnt != '0 && bus.penable_i) begin
            cnt <= cnt - 4'd1;
        end
    end

    apb_slv_regfile #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .we   (done && wr && !blocked),
        .waddr(idx),
        .wdata(wdata),
        .re   (setup && !bus.pwrite_i),
        .rzero(rzero),
        .raddr(bus.paddr_i[APB_ADDR_LSB +: IW]),
        .rdata(bus.prdata_o)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: scoreboard bench for apb_slave_mem with WAIT_CYCLES=2 (dut0) and WAIT_CYCLES=0 (dut1)
module tb_apb_slave_mem;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  psel_d;
    logic [1:0]  penable_d;
    logic [1:0]  pwrite_d;
    logic [31:0] paddr_d [2];
    logic [31:0] pwdata_d [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0();
    apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus1();

    assign bus0.psel_i    = psel_d[0];
    assign bus0.penable_i = penable_d[0];
    assign bus0.pwrite_i  = pwrite_d[0];
    assign bus0.paddr_i   = paddr_d[0];
    assign bus0.pwdata_i  = pwdata_d[0];
    assign bus1.psel_i    = psel_d[1];
    assign bus1.penable_i = penable_d[1];
    assign bus1.pwrite_i  = pwrite_d[1];
    assign bus1.paddr_i   = paddr_d[1];
    assign bus1.pwdata_i  = pwdata_d[1];

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    function automatic logic rdy(input int d);
        return d != 0 ? bus1.pready_o : bus0.pready_o;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return d != 0 ? bus1.prdata_o : bus0.prdata_o;
    endfunction

    task automatic cmp(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h want=%h", n, d, act, exp);
        end
    endtask

    // Pop the oldest expectation for this DUT and compare against what it presents at completion
    task automatic check_done(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d != 0 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion dut%0d got=%h want=none", d, rdat(d));
            return;
        end
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (!e.wr) cmp("rdata", d, rdat(d), e.data);
`ifdef APB_SLAVE_PSLVERR_EN
        cmp("pslverr", d, 32'(d != 0 ? bus1.pslverr_o : bus0.pslverr_o), 32'(e.err));
`endif
    endtask

    // Monitor: a completion is pready with psel and penable held
    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.pready_o && psel_d[0] && penable_d[0]) check_done(0);
            if (bus1.pready_o && psel_d[1] && penable_d[1]) check_done(1);
        end
    end

    // Full transfer: setup, access until pready (bounded), latency checked; bus left in access for back-to-back use
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat);
        int   lat;
        exp_t e;
        @(posedge clk); #1;
        psel_d[d] = 1'b1; penable_d[d] = 1'b0; pwrite_d[d] = wr; paddr_d[d] = a; pwdata_d[d] = wd;
        e.wr = wr; e.data = erd; e.err = eerr;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk); #1;
        penable_d[d] = 1'b1;
        lat = 1;
        while (!rdy(d) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        cmp("latency", d, 32'(lat), 32'(elat));
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        psel_d[d] = 1'b0; penable_d[d] = 1'b0;
    endtask

    initial begin
        psel_d = '0; penable_d = '0; pwrite_d = '0;
        for (int i = 0; i < 2; i++) begin
            paddr_d[i] = '0;
            pwdata_d[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cmp("reset_pready", d, 32'(rdy(d)), 32'd0);
            cmp("reset_prdata", d, rdat(d), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0, 3);
        idle(0);

        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 32'd0, 1'b0, 3);
        xfer(0, 1'b0, 32'h08, 32'd0, 32'hDEADBEEF, 1'b0, 3);
        xfer(0, 1'b1, 32'h10, 32'h00000077, 32'd0, 1'b0, 3);
        idle(0);
        cmp("prdata_hold", 0, rdat(0), 32'hDEADBEEF);

        xfer(1, 1'b1, 32'h0, 32'h11, 32'd0, 1'b0, 1);
        xfer(1, 1'b1, 32'h4, 32'h22, 32'd0, 1'b0, 1);
        xfer(1, 1'b0, 32'h0, 32'd0, 32'h11, 1'b0, 1);
        xfer(1, 1'b0, 32'h4, 32'd0, 32'h22, 1'b0, 1);
        idle(1);
        cmp("idle_pready", 1, 32'(rdy(1)), 32'd0);

        @(posedge clk); #1;
        psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1; paddr_d[0] = 32'h0C; pwdata_d[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable_d[0] = 1'b1;
        cmp("abort_pready", 0, 32'(rdy(0)), 32'd0);
        idle(0);
        xfer(0, 1'b0, 32'h0C, 32'd0, 32'd0, 1'b0, 3);

        xfer(0, 1'b1, 32'h14, 32'h5555AAAA, 32'd0, 1'b0, 3);
        xfer(0, 1'b0, 32'h14, 32'd0, 32'h5555AAAA, 1'b0, 3);

        xfer(0, 1'b1, 32'h00, 32'hCAFE0000, 32'd0, 1'b0, 3);
`ifdef APB_SLAVE_PSLVERR_EN
        xfer(0, 1'b1, 32'h40, 32'h0000BAD0, 32'd0, 1'b1, 3);
        xfer(0, 1'b1, 32'h02, 32'h0000BAD2, 32'd0, 1'b1, 3);
        xfer(0, 1'b0, 32'h00, 32'd0, 32'hCAFE0000, 1'b0, 3);
        xfer(0, 1'b0, 32'h40, 32'd0, 32'd0, 1'b1, 3);
        xfer(0, 1'b0, 32'h08, 32'd0, 32'hDEADBEEF, 1'b0, 3);
        idle(0);
        cmp("pslverr_idle", 0, 32'(bus0.pslverr_o), 32'd0);
`else
        xfer(0, 1'b1, 32'h48, 32'h0000BAD0, 32'd0, 1'b0, 3);
        xfer(0, 1'b0, 32'h08, 32'd0, 32'h0000BAD0, 1'b0, 3);
        xfer(0, 1'b0, 32'h0B, 32'd0, 32'h0000BAD0, 1'b0, 3);
        xfer(0, 1'b0, 32'h40, 32'd0, 32'hCAFE0000, 1'b0, 3);
        idle(0);
`endif

        @(posedge clk); #1;
        psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1; paddr_d[0] = 32'h04; pwdata_d[0] = 32'h12345678;
        @(posedge clk); #1;
        penable_d[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        psel_d[0] = 1'b0; penable_d[0] = 1'b0;
        cmp("midreset_pready", 0, 32'(rdy(0)), 32'd0);
        cmp("midreset_prdata", 0, rdat(0), 32'd0);
        xfer(0, 1'b0, 32'h04, 32'd0, 32'd0, 1'b0, 3);
        xfer(0, 1'b0, 32'h08, 32'd0, 32'd0, 1'b0, 3);
        idle(0);
        xfer(1, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1);
        idle(1);

        @(posedge clk); #1;
        cmp("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
